// File: rtl/count_ctrl_pkg.sv
// Shared types and default constants for the count_ctrl run/stop/clear controller.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int unsigned DEF_DIV       = 4;
  localparam int unsigned DEF_DB_CYCLES = 3;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: accepts a new level after DB_CYCLES consecutive mismatching
// samples and emits a one-cycle press pulse on each accepted 0->1 change.
module btn_debounce
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (din != level) begin
        if (cnt == LAST) begin
          level <= din;
          cnt   <= '0;
          press <= din;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// Run/stop/clear controller driving a downstream counter via a prescaled enable.
// Define COUNT_CTRL_SYNC_EN to put a 2-flop synchronizer ahead of each debouncer.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DIV       = DEF_DIV,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_run,
  input  logic btn_clr,
  output logic cnt_en,
  output logic cnt_clr_n,
  output logic running
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

  logic run_in, clr_in;
  logic run_level, run_press, clr_level, clr_press;
  logic run_evt, clr_evt;
  logic [PW-1:0] pre;
  state_t state, nxt;

`ifdef COUNT_CTRL_SYNC_EN
  logic [1:0] run_sync, clr_sync;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      run_sync <= '0;
      clr_sync <= '0;
    end else begin
      run_sync <= {run_sync[0], btn_run};
      clr_sync <= {clr_sync[0], btn_clr};
    end
  end

  assign run_in = run_sync[1];
  assign clr_in = clr_sync[1];
`else
  assign run_in = btn_run;
  assign clr_in = btn_clr;
`endif

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
    .clk   (clk),
    .clr   (clr),
    .din   (run_in),
    .level (run_level),
    .press (run_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
    .clk   (clk),
    .clr   (clr),
    .din   (clr_in),
    .level (clr_level),
    .press (clr_press)
  );

  // A press always coincides with its level going high; gating keeps both used.
  assign run_evt = run_press & run_level;
  assign clr_evt = clr_press & clr_level;

  always_comb begin
    nxt = state;
    case (state)
      STOP:    if (clr_evt) nxt = CLEAR; else if (run_evt) nxt = RUN;
      RUN:     if (clr_evt) nxt = CLEAR; else if (run_evt) nxt = STOP;
      CLEAR:   nxt = STOP;
      default: nxt = STOP;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state
  // register; a tick is dropped when the same edge enters CLEAR.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= STOP;
      pre       <= '0;
      cnt_en    <= 1'b0;
      cnt_clr_n <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= nxt;
      running   <= (nxt == RUN);
      cnt_clr_n <= (nxt != CLEAR);
      cnt_en    <= (state == RUN) && (pre == PLAST) && (nxt != CLEAR);
      if (state == RUN && nxt == RUN)
        pre <= (pre == PLAST) ? '0 : pre + 1'b1;
      else
        pre <= '0;
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: directed scenarios plus randomized buttons
// compared every cycle against a window-based behavioural model.
module tb_count_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 3;
`ifdef COUNT_CTRL_SYNC_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  localparam int M_STOP  = 0;
  localparam int M_RUN   = 1;
  localparam int M_CLEAR = 2;

  logic clk, clr, btn_run, btn_clr;
  logic cnt_en, cnt_clr_n, running;

  int checks = 0;
  int errors = 0;

  count_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_run   (btn_run),
    .btn_clr   (btn_clr),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .running   (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: a level flips once the last DB samples all disagree with it.
  bit m_lvl[2];
  bit m_prs[2];
  bit hist[2][$];
  bit syncq[2][$];
  int m_mode, m_age;
  bit exp_en, exp_clrn, exp_run;

  always @(posedge clk or posedge clr) begin : model
    int nx;
    bit raw[2];
    bit eff, flip;
    if (clr) begin
      for (int b = 0; b < 2; b++) begin
        m_lvl[b] = 1'b0;
        m_prs[b] = 1'b0;
        hist[b].delete();
        syncq[b].delete();
        syncq[b].push_back(1'b0);
        syncq[b].push_back(1'b0);
      end
      m_mode = M_STOP; m_age = 0;
      exp_en = 1'b0; exp_clrn = 1'b1; exp_run = 1'b0;
    end else begin
      if (m_mode == M_CLEAR) nx = M_STOP;
      else if (m_prs[1]) nx = M_CLEAR;
      else if (m_prs[0]) nx = (m_mode == M_RUN) ? M_STOP : M_RUN;
      else nx = m_mode;
      exp_en   = (m_mode == M_RUN) && (((m_age + 1) % DIV) == 0) && (nx != M_CLEAR);
      m_age    = (m_mode == M_RUN && nx == M_RUN) ? m_age + 1 : 0;
      exp_run  = (nx == M_RUN);
      exp_clrn = (nx != M_CLEAR);
      m_mode   = nx;
      raw[0] = btn_run;
      raw[1] = btn_clr;
      for (int b = 0; b < 2; b++) begin
`ifdef COUNT_CTRL_SYNC_EN
        syncq[b].push_back(raw[b]);
        eff = syncq[b].pop_front();
`else
        eff = raw[b];
`endif
        hist[b].push_back(eff);
        if (hist[b].size() > DB) void'(hist[b].pop_front());
        flip = (hist[b].size() == DB);
        for (int i = 0; i < hist[b].size(); i++)
          if (hist[b][i] == m_lvl[b]) flip = 1'b0;
        m_prs[b] = 1'b0;
        if (flip) begin
          m_lvl[b] = !m_lvl[b];
          m_prs[b] = m_lvl[b];
          hist[b].delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({cnt_en, cnt_clr_n, running} !== {exp_en, exp_clrn, exp_run}) begin
      errors++;
      $display("FAIL model_cmp t=%0t en/clr_n/run got %b%b%b expected %b%b%b",
               $time, cnt_en, cnt_clr_n, running, exp_en, exp_clrn, exp_run);
    end
    checks++;
    if (cnt_en === 1'b1 && cnt_clr_n === 1'b0) begin
      errors++;
      $display("FAIL en_with_clear t=%0t cnt_en=%b cnt_clr_n=%b required not both active",
               $time, cnt_en, cnt_clr_n);
    end
  end

  // Event log for the directed scenarios.
  int cyc = 0;
  int run_rise[$], en_cyc[$], clr_cyc[$];
  bit prev_run = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (running === 1'b1 && !prev_run) run_rise.push_back(cyc);
    if (cnt_en === 1'b1) en_cyc.push_back(cyc);
    if (cnt_clr_n === 1'b0) clr_cyc.push_back(cyc);
    prev_run = (running === 1'b1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    run_rise.delete();
    en_cyc.delete();
    clr_cyc.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk); #1;
    clr = 1'b1; btn_run = 1'b0; btn_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic press_btns(input bit r, input bit c, input int hold, output int start);
    @(negedge clk); #1;
    start = cyc;
    btn_run = r; btn_clr = c;
    repeat (hold) @(negedge clk);
    #1 btn_run = 1'b0; btn_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int s, n_after, found;
    clr = 1'b1; btn_run = 1'b0; btn_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cnt_en", int'(cnt_en), 0);
    chk("reset_cnt_clr_n", int'(cnt_clr_n), 1);
    chk("reset_running", int'(running), 0);
    #1 clr = 1'b0;

    // Run press: one event, first tick DIV cycles after running rises.
    clear_log();
    press_btns(1'b1, 1'b0, 5, s);
    idle(20);
    chk("run_press_count", run_rise.size(), 1);
    if (run_rise.size() > 0) chk("run_latency", run_rise[0] - s, LAT);
    if (run_rise.size() > 0 && en_cyc.size() > 0) chk("first_tick", en_cyc[0] - run_rise[0], 4);
    if (en_cyc.size() > 1) chk("tick_period", en_cyc[1] - en_cyc[0], 4);
    chk("still_running", int'(running), 1);

    // Clear while running: one-cycle clear pulse, then stopped.
    clear_log();
    press_btns(1'b0, 1'b1, 5, s);
    idle(20);
    chk("clear_pulse_len", clr_cyc.size(), 1);
    n_after = 0;
    if (clr_cyc.size() > 0)
      foreach (en_cyc[i]) if (en_cyc[i] >= clr_cyc[0]) n_after++;
    chk("no_tick_after_clear", n_after, 0);
    chk("stopped_after_clear", int'(running), 0);

    // Glitch shorter than the debounce window.
    apply_reset();
    clear_log();
    press_btns(1'b1, 1'b0, 2, s);
    idle(15);
    chk("glitch_no_run", run_rise.size(), 0);
    chk("glitch_no_tick", en_cyc.size(), 0);

    // Simultaneous presses: clear wins, running never asserts.
    clear_log();
    press_btns(1'b1, 1'b1, 5, s);
    idle(20);
    chk("both_clear_pulse", clr_cyc.size(), 1);
    chk("both_no_run", run_rise.size(), 0);

    // Asynchronous reset during a tick.
    apply_reset();
    press_btns(1'b1, 1'b0, 5, s);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (cnt_en === 1'b1) found = 1;
    end
    chk("tick_seen_before_reset", found, 1);
    #2 clr = 1'b1;
    #1;
    chk("async_cnt_en", int'(cnt_en), 0);
    chk("async_cnt_clr_n", int'(cnt_clr_n), 1);
    chk("async_running", int'(running), 0);
    @(negedge clk); #1 clr = 1'b0;
    clear_log();
    idle(20);
    chk("no_tick_after_reset", en_cyc.size(), 0);
    chk("no_run_after_reset", run_rise.size(), 0);

    // Randomized buttons with occasional asynchronous resets.
    for (int seg = 0; seg < 400; seg++) begin
      int hold;
      @(negedge clk); #1;
      btn_run = ($urandom_range(0, 2) == 0);
      btn_clr = ($urandom_range(0, 6) == 0);
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) begin
        #1 clr = 1'b1;
        @(negedge clk); #2 clr = 1'b0;
      end
      repeat (hold - 1) @(negedge clk);
    end
    btn_run = 1'b0; btn_clr = 1'b0;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
